// File: rtl/rv_ctl_pkg.sv
// Shared types and encodings for the multicycle RV32I control plane:
// FSM states, opcodes and the datapath mux select codes.
package rv_ctl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    LW_MEM    = 4'd3,
    LW_WB     = 4'd4,
    SW_MEM    = 4'd5,
    ALU_REG   = 4'd6,
    ALU_IMM   = 4'd7,
    ALU_WB    = 4'd8,
    BR_EXEC   = 4'd9,
    JAL_EXEC  = 4'd10,
    JALR_EXEC = 4'd11,
    LUI_WB    = 4'd12,
    TRAP      = 4'd13
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] WB_PC     = 2'b00;
  localparam logic [1:0] WB_ALUOUT = 2'b01;
  localparam logic [1:0] WB_MDR    = 2'b10;
  localparam logic [1:0] WB_IMM    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] A_REG = 2'b00;
  localparam logic [1:0] A_PCC = 2'b01;
  localparam logic [1:0] A_PC  = 2'b10;

  localparam logic [1:0] B_REG    = 2'b00;
  localparam logic [1:0] B_IMM    = 2'b01;
  localparam logic [1:0] B_CONST4 = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // States that own the memory port and therefore run the wait counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == LW_MEM) || (s == SW_MEM);
  endfunction

endpackage

// File: rtl/rv_br_cond.sv
// Branch condition decode: maps funct3 and ALU flags to taken/legal.
module rv_br_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       take,
  output logic       legal
);

  always_comb begin
    take  = 1'b0;
    legal = 1'b1;
    case (funct3)
      3'b000:  take = zero;
      3'b001:  take = ~zero;
      3'b100:  take = lt;
      3'b101:  take = ~lt;
      3'b110:  take = ltu;
      3'b111:  take = ~ltu;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctl.sv
// Multicycle RV32I control FSM with memory handshake, wait-state timeout,
// illegal-instruction trap and retired-instruction pulse.
module rv_mc_ctl
  import rv_ctl_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 15,
  parameter int TW              = 4,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        memrw,
  output logic [1:0]  pcsource,
  output logic        pcwrite,
  output logic        pccen,
  output logic        irwrite,
  output logic        mdrwrite,
  output logic [1:0]  wbsel,
  output logic        regwen,
  output logic [2:0]  immsel,
  output logic [1:0]  asel,
  output logic [1:0]  bsel,
  output logic [3:0]  alusel,
  output logic        illegal,
  output logic        timeout,
  output logic        instret,
  output logic [3:0]  state_o
);

  localparam bit            TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [TW-1:0] WAIT_LIMIT = TW'(MEM_TIMEOUT);

  state_t        state_reg, state_next;
  logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          illegal_reg, illegal_next;
  logic          timeout_reg, timeout_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic       br_take, br_legal;
  logic       wait_expired;
  logic       illegal_path;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign bit30        = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  rv_br_cond u_br_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .ltu    (ltu),
    .take   (br_take),
    .legal  (br_legal)
  );

  // A ready arriving on the limit cycle still completes the access.
  assign wait_expired = TIMEOUT_EN && is_mem_state(state_reg) &&
                        !mem_ready && (wait_cnt_reg == WAIT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      illegal_reg  <= illegal_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    timeout_next = timeout_reg;
    illegal_path = 1'b0;
    mem_req      = 1'b0;
    memrw        = 1'b0;
    pcsource     = PC_INC;
    pcwrite      = 1'b0;
    pccen        = 1'b0;
    irwrite      = 1'b0;
    mdrwrite     = 1'b0;
    wbsel        = WB_PC;
    regwen       = 1'b0;
    immsel       = IMM_I;
    asel         = A_REG;
    bsel         = B_REG;
    alusel       = ALU_ADD;
    instret      = 1'b0;

    case (state_reg)
      FETCH: begin
        mem_req = 1'b1;
        asel    = A_PC;
        bsel    = B_CONST4;
        if (mem_ready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          pccen      = 1'b1;
          state_next = DECODE;
        end else if (wait_expired) begin
          state_next   = TRAP;
          timeout_next = 1'b1;
        end
      end
      DECODE: begin
        // Speculative branch target into ALUOut while dispatching.
        asel   = A_PCC;
        bsel   = B_IMM;
        immsel = IMM_B;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_next = MEM_ADDR;
          OPC_OP:              state_next = ALU_REG;
          OPC_OP_IMM:          state_next = ALU_IMM;
          OPC_BRANCH: begin
            if (br_legal) state_next = BR_EXEC;
            else          illegal_path = 1'b1;
          end
          OPC_JAL:             state_next = JAL_EXEC;
          OPC_JALR:            state_next = JALR_EXEC;
          OPC_LUI:             state_next = LUI_WB;
          default:             illegal_path = 1'b1;
        endcase
        if (illegal_path) begin
          if (TRAP_ON_ILLEGAL) begin
            state_next   = TRAP;
            illegal_next = 1'b1;
          end else begin
            state_next = FETCH;
          end
        end
      end
      MEM_ADDR: begin
        bsel = B_IMM;
        if (opcode == OPC_STORE) begin
          immsel     = IMM_S;
          state_next = SW_MEM;
        end else begin
          immsel     = IMM_I;
          state_next = LW_MEM;
        end
      end
      LW_MEM: begin
        mem_req  = 1'b1;
        mdrwrite = mem_ready;
        if (mem_ready) begin
          state_next = LW_WB;
        end else if (wait_expired) begin
          state_next   = TRAP;
          timeout_next = 1'b1;
        end
      end
      LW_WB: begin
        wbsel      = WB_MDR;
        regwen     = 1'b1;
        instret    = 1'b1;
        state_next = FETCH;
      end
      SW_MEM: begin
        mem_req = 1'b1;
        memrw   = 1'b1;
        if (mem_ready) begin
          instret    = 1'b1;
          state_next = FETCH;
        end else if (wait_expired) begin
          state_next   = TRAP;
          timeout_next = 1'b1;
        end
      end
      ALU_REG: begin
        alusel     = {funct3, bit30};
        state_next = ALU_WB;
      end
      ALU_IMM: begin
        // Only the shift-right group uses bit30 as an opcode bit; elsewhere it is immediate.
        bsel       = B_IMM;
        immsel     = IMM_I;
        alusel     = {funct3, (funct3 == 3'b101) ? bit30 : 1'b0};
        state_next = ALU_WB;
      end
      ALU_WB: begin
        wbsel      = WB_ALUOUT;
        regwen     = 1'b1;
        instret    = 1'b1;
        state_next = FETCH;
      end
      BR_EXEC: begin
        alusel     = ALU_SUB;
        pcsource   = PC_ALUOUT;
        pcwrite    = br_take;
        instret    = 1'b1;
        state_next = FETCH;
      end
      JAL_EXEC: begin
        immsel     = IMM_J;
        asel       = A_PCC;
        bsel       = B_IMM;
        pcsource   = PC_INC;
        pcwrite    = 1'b1;
        wbsel      = WB_PC;
        regwen     = 1'b1;
        instret    = 1'b1;
        state_next = FETCH;
      end
      JALR_EXEC: begin
        immsel     = IMM_I;
        asel       = A_REG;
        bsel       = B_IMM;
        pcsource   = PC_JALR;
        pcwrite    = 1'b1;
        wbsel      = WB_PC;
        regwen     = 1'b1;
        instret    = 1'b1;
        state_next = FETCH;
      end
      LUI_WB: begin
        immsel     = IMM_U;
        wbsel      = WB_IMM;
        regwen     = 1'b1;
        instret    = 1'b1;
        state_next = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase

    // Count only while holding in a memory state; any departure clears it.
    if (is_mem_state(state_reg) && !mem_ready && (state_next == state_reg))
      wait_cnt_next = wait_cnt_reg + TW'(1);
    else
      wait_cnt_next = '0;
  end

  assign illegal = illegal_reg;
  assign timeout = timeout_reg;
  assign state_o = state_reg;

endmodule

// File: tb/tb_rv_mc_ctl.sv
// Scoreboard bench for rv_mc_ctl: directed instruction sequences push expected
// per-cycle controls; a negedge monitor pops and compares two DUT variants.
module tb_rv_mc_ctl;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       memrw;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pccen;
    logic       irwrite;
    logic       mdrwrite;
    logic [1:0] wbsel;
    logic       regwen;
    logic [2:0] immsel;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [3:0] alusel;
    logic       illegal;
    logic       timeout;
    logic       instret;
  } ctl_t;

  typedef struct {
    string nm;
    ctl_t  ea;
    ctl_t  eb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero, lt, ltu, mem_ready;

  logic       mem_req_a, memrw_a, pcwrite_a, pccen_a, irwrite_a, mdrwrite_a, regwen_a;
  logic       illegal_a, timeout_a, instret_a;
  logic [1:0] pcsource_a, wbsel_a, asel_a, bsel_a;
  logic [2:0] immsel_a;
  logic [3:0] alusel_a, st_a;
  logic       mem_req_b, memrw_b, pcwrite_b, pccen_b, irwrite_b, mdrwrite_b, regwen_b;
  logic       illegal_b, timeout_b, instret_b;
  logic [1:0] pcsource_b, wbsel_b, asel_b, bsel_b;
  logic [2:0] immsel_b;
  logic [3:0] alusel_b, st_b;
  ctl_t       act_a, act_b;

  exp_t sbq[$];
  exp_t mon_x;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rv_mc_ctl #(.MEM_TIMEOUT(15), .TW(4), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req_a), .memrw(memrw_a),
    .pcsource(pcsource_a), .pcwrite(pcwrite_a), .pccen(pccen_a),
    .irwrite(irwrite_a), .mdrwrite(mdrwrite_a), .wbsel(wbsel_a),
    .regwen(regwen_a), .immsel(immsel_a), .asel(asel_a), .bsel(bsel_a),
    .alusel(alusel_a), .illegal(illegal_a), .timeout(timeout_a),
    .instret(instret_a), .state_o(st_a)
  );

  rv_mc_ctl #(.MEM_TIMEOUT(15), .TW(4), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req_b), .memrw(memrw_b),
    .pcsource(pcsource_b), .pcwrite(pcwrite_b), .pccen(pccen_b),
    .irwrite(irwrite_b), .mdrwrite(mdrwrite_b), .wbsel(wbsel_b),
    .regwen(regwen_b), .immsel(immsel_b), .asel(asel_b), .bsel(bsel_b),
    .alusel(alusel_b), .illegal(illegal_b), .timeout(timeout_b),
    .instret(instret_b), .state_o(st_b)
  );

  assign act_a = {st_a, mem_req_a, memrw_a, pcsource_a, pcwrite_a, pccen_a, irwrite_a,
                  mdrwrite_a, wbsel_a, regwen_a, immsel_a, asel_a, bsel_a, alusel_a,
                  illegal_a, timeout_a, instret_a};
  assign act_b = {st_b, mem_req_b, memrw_b, pcsource_b, pcwrite_b, pccen_b, irwrite_b,
                  mdrwrite_b, wbsel_b, regwen_b, immsel_b, asel_b, bsel_b, alusel_b,
                  illegal_b, timeout_b, instret_b};

  // Monitor: one expected entry per cycle, compared mid-cycle against both variants.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_x = sbq.pop_front();
      tests = tests + 2;
      if (act_a !== mon_x.ea) begin
        fails = fails + 1;
        $display("[TB] FAIL %s trap_dut actual=%h required=%h", mon_x.nm, act_a, mon_x.ea);
      end
      if (act_b !== mon_x.eb) begin
        fails = fails + 1;
        $display("[TB] FAIL %s notrap_dut actual=%h required=%h", mon_x.nm, act_b, mon_x.eb);
      end
      $display("[TB] %s state=%0d/%0d ctl=%h/%h", mon_x.nm, st_a, st_b, act_a, act_b);
    end
  end

  function automatic ctl_t zs(input logic [3:0] st);
    ctl_t c;
    c       = '0;
    c.state = st;
    return c;
  endfunction

  function automatic ctl_t fetch_e(input logic rdy);
    ctl_t c;
    c         = zs(4'd0);
    c.mem_req = 1'b1;
    c.asel    = 2'b10;
    c.bsel    = 2'b10;
    c.irwrite = rdy;
    c.pcwrite = rdy;
    c.pccen   = rdy;
    return c;
  endfunction

  function automatic ctl_t decode_e();
    ctl_t c;
    c        = zs(4'd1);
    c.asel   = 2'b01;
    c.bsel   = 2'b01;
    c.immsel = 3'b010;
    return c;
  endfunction

  task automatic step(input string nm, input ctl_t ea, input ctl_t eb);
    exp_t x;
    x.nm = nm;
    x.ea = ea;
    x.eb = eb;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input string nm, input ctl_t e);
    step(nm, e, e);
  endtask

  task automatic front(input string nm, input logic [31:0] ins);
    instr     = ins;
    mem_ready = 1'b1;
    step2({nm, "_fetch"}, fetch_e(1'b1));
    step2({nm, "_decode"}, decode_e());
  endtask

  task automatic do_reset(input string nm);
    rst       = 1'b1;
    mem_ready = 1'b0;
    step2({nm, "_rst"}, fetch_e(1'b0));
    rst = 1'b0;
    step2({nm, "_post"}, fetch_e(1'b0));
  endtask

  task automatic branch(input string nm, input logic [31:0] ins, input logic z,
                        input logic l, input logic lu, input logic take);
    ctl_t e;
    zero = z;
    lt   = l;
    ltu  = lu;
    front(nm, ins);
    e          = zs(4'd9);
    e.alusel   = 4'b0001;
    e.pcsource = 2'b01;
    e.instret  = 1'b1;
    e.pcwrite  = take;
    step2({nm, "_exec"}, e);
  endtask

  task automatic alu_wb(input string nm);
    ctl_t e;
    e         = zs(4'd8);
    e.wbsel   = 2'b01;
    e.regwen  = 1'b1;
    e.instret = 1'b1;
    step2({nm, "_wb"}, e);
  endtask

  task automatic sw_wait(input string nm, input int n);
    ctl_t e;
    front(nm, 32'h0020_A423);
    e        = zs(4'd2);
    e.bsel   = 2'b01;
    e.immsel = 3'b001;
    step2({nm, "_addr"}, e);
    mem_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      e         = zs(4'd5);
      e.mem_req = 1'b1;
      e.memrw   = 1'b1;
      step2({nm, "_wait"}, e);
    end
  endtask

  task automatic illegal_case(input string nm, input logic [31:0] ins);
    ctl_t ea;
    front(nm, ins);
    mem_ready  = 1'b0;
    ea         = zs(4'd13);
    ea.illegal = 1'b1;
    step({nm, "_trap"}, ea, fetch_e(1'b0));
    step({nm, "_hold"}, ea, fetch_e(1'b0));
    do_reset(nm);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t e;
    rst = 1'b1; instr = 32'h0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step2("reset", fetch_e(1'b0));
    rst = 1'b0;
    step2("post_reset", fetch_e(1'b0));

    // ADDI x1, x0, 5
    front("addi", 32'h0050_0093);
    e = zs(4'd7); e.bsel = 2'b01; step2("addi_exec", e);
    alu_wb("addi");
    // SUB: bit30 selects subtract
    front("sub", 32'h4000_0033);
    e = zs(4'd6); e.alusel = 4'b0001; step2("sub_exec", e);
    alu_wb("sub");
    // SRAI keeps bit30, ADDI with bit30 set in the immediate drops it
    front("srai", 32'h4000_5013);
    e = zs(4'd7); e.bsel = 2'b01; e.alusel = 4'b1011; step2("srai_exec", e);
    alu_wb("srai");
    front("addi_b30", 32'h4000_0013);
    e = zs(4'd7); e.bsel = 2'b01; step2("addi_b30_exec", e);
    alu_wb("addi_b30");

    // LW with three wait cycles
    front("lw", 32'h0080_A103);
    e = zs(4'd2); e.bsel = 2'b01; step2("lw_addr", e);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = zs(4'd3); e.mem_req = 1'b1; step2("lw_wait", e);
    end
    mem_ready = 1'b1;
    e = zs(4'd3); e.mem_req = 1'b1; e.mdrwrite = 1'b1; step2("lw_mem", e);
    e = zs(4'd4); e.wbsel = 2'b10; e.regwen = 1'b1; e.instret = 1'b1; step2("lw_wb", e);

    branch("bne_nz", 32'h0000_1063, 1'b0, 1'b0, 1'b0, 1'b1);
    branch("bne_z", 32'h0000_1063, 1'b1, 1'b0, 1'b0, 1'b0);
    branch("bgeu", 32'h0000_7063, 1'b0, 1'b0, 1'b0, 1'b1);
    branch("blt", 32'h0000_4063, 1'b0, 1'b1, 1'b0, 1'b1);
    branch("beq_nz", 32'h0000_0063, 1'b0, 1'b0, 1'b0, 1'b0);
    branch("bge_lt", 32'h0000_5063, 1'b0, 1'b1, 1'b1, 1'b0);

    front("jal", 32'h0000_006F);
    e = zs(4'd10); e.immsel = 3'b011; e.asel = 2'b01; e.bsel = 2'b01;
    e.pcwrite = 1'b1; e.regwen = 1'b1; e.instret = 1'b1;
    step2("jal_exec", e);
    front("lui", 32'h0000_10B7);
    e = zs(4'd12); e.immsel = 3'b100; e.wbsel = 2'b11; e.regwen = 1'b1; e.instret = 1'b1;
    step2("lui_wb", e);
    front("jalr", 32'h0000_8067);
    e = zs(4'd11); e.bsel = 2'b01; e.pcsource = 2'b10;
    e.pcwrite = 1'b1; e.regwen = 1'b1; e.instret = 1'b1;
    step2("jalr_exec", e);

    // Reset landing in the middle of a load access
    front("lw_rst", 32'h0080_A103);
    e = zs(4'd2); e.bsel = 2'b01; step2("lw_rst_addr", e);
    mem_ready = 1'b0;
    e = zs(4'd3); e.mem_req = 1'b1; step2("lw_rst_wait", e);
    do_reset("lw_mid");

    // SW: ready on the limit cycle completes with no trap
    sw_wait("sw_late", 15);
    mem_ready = 1'b1;
    e = zs(4'd5); e.mem_req = 1'b1; e.memrw = 1'b1; e.instret = 1'b1;
    step2("sw_late_done", e);
    step2("sw_late_next", fetch_e(1'b1));
    step2("sw_late_next_dec", decode_e());
    do_reset("sw_late");

    // SW with memory never ready: trap, sticky timeout, controls idle
    sw_wait("sw_to", 16);
    for (int i = 0; i < 3; i++) begin
      e = zs(4'd13); e.timeout = 1'b1; step2("sw_to_trap", e);
    end
    do_reset("sw_to");

    illegal_case("fence", 32'h0000_000F);
    illegal_case("br010", 32'h0000_2063);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
